// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the corev2 front end.
//   XLEN             : architectural register / address width.
//   RESET_PC_DEFAULT : default first fetch address after reset.
//   fetch_entry_t    : one fetched instruction word together with its PC.
//   word_align()     : clears the byte-offset bits of an address.
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   // Masking keeps every input bit in use, so the helper is lint-quiet.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous in-order FIFO with registered head, used both for the
//   instruction queue (fetch_entry_t) and for the PC side-queue (plain PCs).
//   Ports:
//     clk, reset_n      : clock, asynchronous active-low reset
//     clear_i           : drop all entries (wins over push/pop)
//     push_i, data_i    : write an entry (accepted when not full, or when
//                         a pop happens in the same cycle)
//     pop_i             : remove the head entry (ignored when empty)
//     data_o            : head entry
//     full_o, empty_o   : occupancy flags
//     count_o           : number of stored entries
// -----------------------------------------------------------------------------
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  T                       data_i,
   input  logic                   pop_i,
   output T                       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic          do_push,  do_pop;

   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      // A full queue still accepts a write when the head leaves this cycle.
      do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is data only; validity is tracked by the counters above.
   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
//   corev2 instruction fetch stage. Owns the PC, issues word requests to
//   instruction memory (req/gnt/rvalid), buffers responses with their PCs and
//   hands them to the decoder over valid/ready. A flush restarts fetch at a
//   new PC and discards everything older.
//   Ports:
//     clk, reset_n                 : clock, asynchronous active-low reset
//     imem_req_o, imem_addr_o      : fetch request and word address
//     imem_gnt_i                   : request accepted this cycle
//     imem_rvalid_i, imem_rdata_i  : in-order response
//     flush_i, flush_pc_i          : redirect strobe and target
//     instr_v_o, instr_o, pc_o     : head instruction to decoder
//     instr_ready_i                : decoder consumes the head
// -----------------------------------------------------------------------------
module ifetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] flush_pc_i,
   output logic            instr_v_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   input  logic            instr_ready_i
);

   localparam int CW = $clog2(DEPTH) + 1;
   // Drops are not bounded by the credit window (several flushes can stack
   // up against a slow memory), so they get a wider counter.
   localparam int DW = 8;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic            run_q,      run_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   pend_q,     pend_d;
   logic [DW-1:0]   drop_q,     drop_d;

   logic            credit, req, grant, rsp_keep, rsp_drop;

   logic            q_push, q_pop, q_full, q_empty;
   fetch_entry_t    q_wdata, q_head;
   logic [CW-1:0]   q_count;

   logic            sq_push, sq_pop, sq_full, sq_empty;
   logic [XLEN-1:0] sq_head;
   logic [CW-1:0]   sq_count;

   always_comb begin
      // Credit counts buffered plus kept-in-flight words; a pop this cycle
      // only frees space for the next cycle.
      credit   = ({1'b0, q_count} + {1'b0, pend_q}) < DEPTH_C;
      req      = run_q && !flush_i && credit;
      grant    = req && imem_gnt_i;
      rsp_drop = imem_rvalid_i && (drop_q != '0);
      // With nothing kept in flight the side-queue is empty: stray data ignored.
      rsp_keep = imem_rvalid_i && (drop_q == '0) && !sq_empty;

      run_d      = 1'b1;
      fetch_pc_d = fetch_pc_q;
      pend_d     = pend_q;
      drop_d     = drop_q;

      if (flush_i) begin
         // Every response still owed becomes a drop, minus the one that
         // arrives (and is thrown away) right now.
         fetch_pc_d = word_align(flush_pc_i);
         pend_d     = '0;
         drop_d     = drop_q + DW'(pend_q) - DW'(rsp_drop || rsp_keep);
      end else begin
         if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
         pend_d = pend_q + CW'(grant) - CW'(rsp_keep);
         drop_d = drop_q - DW'(rsp_drop);
      end

      q_push  = rsp_keep && !flush_i;
      q_pop   = !q_empty && instr_ready_i && !flush_i;
      q_wdata = '{instr: imem_rdata_i, pc: sq_head};

      sq_push = grant;
      sq_pop  = rsp_keep && !flush_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q      <= 1'b0;
         fetch_pc_q <= RESET_PC;
         pend_q     <= '0;
         drop_q     <= '0;
      end else begin
         run_q      <= run_d;
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_instr_q (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (flush_i),
      .push_i  (q_push),
      .data_i  (q_wdata),
      .pop_i   (q_pop),
      .data_o  (q_head),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   // Holds the address of each kept request so the response can be tagged.
   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (logic [XLEN-1:0])
   ) u_pc_q (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (flush_i),
      .push_i  (sq_push),
      .data_i  (fetch_pc_q),
      .pop_i   (sq_pop),
      .data_o  (sq_head),
      .full_o  (sq_full),
      .empty_o (sq_empty),
      .count_o (sq_count)
   );

   assign imem_req_o  = req;
   assign imem_addr_o = fetch_pc_q;
   assign instr_v_o   = !q_empty;
   // Storage is not reset, so present zeros whenever nothing is valid.
   assign instr_o     = q_empty ? '0 : q_head.instr;
   assign pc_o        = q_empty ? '0 : q_head.pc;

   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset_n)
      imem_rvalid_i |-> ((pend_q != '0) || (drop_q != '0)));

   a_pend_tracks_pcq: assert property (@(posedge clk) disable iff (!reset_n)
      pend_q == sq_count);

   a_no_q_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      (q_push && q_full) |-> q_pop);

   a_no_pcq_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      sq_push |-> !sq_full);

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
   import riscv_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        instr_v_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_ready_i;

   always #5 clk = ~clk;

   ifetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .flush_i       (flush_i),
      .flush_pc_i    (flush_pc_i),
      .instr_v_o     (instr_v_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .instr_ready_i (instr_ready_i)
   );

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   mreq_t mq[$];   // memory: granted, not yet answered
   exp_t  sb[$];   // scoreboard: what the decoder must see next

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int grants   = 0;
   int n_pop    = 0;
   int first_req_cyc = -1;
   int first_v_cyc   = -1;
   int resp_lat = 1;

   bit rand_mem = 0, rand_ready = 0, ready_force = 1;
   bit flush_req = 0, flush_on_busy = 0, post_flush = 0, want_first = 0;
   bit prev_stall = 0;
   logic [31:0] flush_tgt, want_pc, exp_addr, prev_instr, prev_pc;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_req"},     {31'b0, imem_req_o}, 32'd0);
      check_eq({pfx, "_addr"},    imem_addr_o, RST_PC);
      check_eq({pfx, "_instr_v"}, {31'b0, instr_v_o}, 32'd0);
      check_eq({pfx, "_instr"},   instr_o, 32'd0);
      check_eq({pfx, "_pc"},      pc_o, 32'd0);
   endtask

   // One cycle: drive inputs at negedge, then observe and score at negedge+1.
   task automatic step();
      exp_t  e;
      mreq_t m;
      @(negedge clk);
      cyc++;
      imem_gnt_i = rand_mem ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = data_of(mq[0].addr);
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom;
      end
      instr_ready_i = rand_ready ? ($urandom_range(0, 1) == 1) : ready_force;
      flush_i = 1'b0;
      if (flush_req || (flush_on_busy && imem_rvalid_i && instr_v_o)) begin
         flush_i       = 1'b1;
         flush_pc_i    = flush_tgt;
         flush_req     = 0;
         flush_on_busy = 0;
      end
      #1;
      if (first_v_cyc < 0 && instr_v_o) first_v_cyc = cyc;
      if (prev_stall) begin
         check_eq("stall_valid_held", {31'b0, instr_v_o}, 32'd1);
         check_eq("stall_instr_held", instr_o, prev_instr);
         check_eq("stall_pc_held",    pc_o, prev_pc);
      end
      if (post_flush) begin
         check_eq("post_flush_req",     {31'b0, imem_req_o}, 32'd1);
         check_eq("post_flush_addr",    imem_addr_o, want_pc);
         check_eq("post_flush_no_vld",  {31'b0, instr_v_o}, 32'd0);
         post_flush = 0;
      end
      if (imem_rvalid_i) void'(mq.pop_front());
      if (flush_i) begin
         check_eq("req_in_flush", {31'b0, imem_req_o}, 32'd0);
         sb.delete();
         exp_addr   = flush_tgt & ~32'h3;
         want_pc    = exp_addr;
         want_first = 1;
         post_flush = 1;
      end else begin
         if (imem_req_o && imem_gnt_i) begin
            check_eq("req_addr", imem_addr_o, exp_addr);
            e.pc = exp_addr;
            e.instr = data_of(exp_addr);
            sb.push_back(e);
            m.addr = imem_addr_o;
            m.due  = cyc + resp_lat + (rand_mem ? int'($urandom_range(0, 3)) : 0);
            mq.push_back(m);
            exp_addr += 32'd4;
            grants++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
         end
         if (instr_v_o && instr_ready_i) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_pop", {31'b0, instr_v_o}, 32'd0);
            end else begin
               e = sb.pop_front();
               check_eq("dec_pc",    pc_o, e.pc);
               check_eq("dec_instr", instr_o, e.instr);
               if (want_first) check_eq("first_pc_after_flush", pc_o, want_pc);
               want_first = 0;
               n_pop++;
            end
         end
      end
      prev_stall = instr_v_o && !instr_ready_i && !flush_i;
      prev_instr = instr_o;
      prev_pc    = pc_o;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, start, guard;
      reset_n = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      flush_i = 1'b0; flush_pc_i = '0; instr_ready_i = 1'b0;
      exp_addr = RST_PC;
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("rst");
      reset_n = 1'b1;
      #1 check_eq("req_before_first_edge", {31'b0, imem_req_o}, 32'd0);

      // Zero-wait memory, decoder always ready.
      ready_force = 1; resp_lat = 1;
      repeat (12) step();
      check_eq("first_req_cycle",  first_req_cyc, 32'd1);
      check_eq("first_v_latency",  first_v_cyc - first_req_cyc, 32'd2);

      // Decoder stall from an empty queue: exactly DEPTH grants, then req low.
      ready_force = 0; flush_tgt = 32'h0000_0200; flush_req = 1;
      step();
      g0 = grants;
      repeat (8) step();
      check_eq("stall_grants",  grants - g0, 32'd2);
      check_eq("stall_req_low", {31'b0, imem_req_o}, 32'd0);
      check_eq("stall_valid",   {31'b0, instr_v_o}, 32'd1);
      ready_force = 1;
      repeat (12) step();

      // Flush to a misaligned target with slow responses in flight.
      resp_lat = 3;
      repeat (10) step();
      flush_tgt = 32'h0000_1002; flush_req = 1;
      repeat (16) step();
      resp_lat = 1;
      repeat (4) step();

      // Flush coinciding with a response and a pop.
      flush_tgt = 32'h0000_0300; flush_on_busy = 1;
      guard = 0;
      while (flush_on_busy && guard < 50) begin step(); guard++; end
      check_eq("busy_flush_hit", {31'b0, flush_on_busy}, 32'd0);
      repeat (10) step();

      // PC wraps past the top of the address space.
      flush_tgt = 32'hFFFF_FFF8; flush_req = 1;
      repeat (10) step();

      // Reset in the middle of a burst.
      repeat (3) step();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("midrst");
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; flush_i = 1'b0; instr_ready_i = 1'b0;
      mq.delete(); sb.delete();
      exp_addr = RST_PC; prev_stall = 0; post_flush = 0; want_first = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      want_pc = RST_PC; want_first = 1;
      repeat (10) step();

      // Random memory latency and random decoder backpressure.
      rand_mem = 1; rand_ready = 1;
      start = n_pop; guard = 0;
      while ((n_pop - start) < 1000 && guard < 20000) begin step(); guard++; end
      check_eq("rand_1000_done", {31'b0, ((n_pop - start) >= 1000)}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
